// File: rtl/squeeze_weight_fetch.sv
// rtl/squeeze_weight_fetch.sv - walks squeeze weight/bias ROM tiles for a fire layer and streams them out
// One registered tile per beat; cg is the inner counter and fg the outer one.
module squeeze_weight_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16,
    parameter int PAR_CH = 16,
    parameter int PAR_F  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [2:0]                        firesel,
    output logic [2:0]                        firesel_q,
    output logic [PAR_F*PAR_CH*ADDR_W-1:0]    addr,
    output logic [PAR_F*ADDR_W-1:0]           addrfilt,
    input  logic [PAR_F*PAR_CH*DATA_W-1:0]    rom_data,
    input  logic [PAR_F*DATA_W-1:0]           rom_bias,
    output logic                              w_valid,
    input  logic                              w_ready,
    output logic [PAR_F*PAR_CH*DATA_W-1:0]    w_data,
    output logic [PAR_F*DATA_W-1:0]           w_bias,
    output logic                              w_last_ch,
    output logic                              w_last,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t     state, state_nx;
    logic [7:0] fg, cg, fg_nx, cg_nx;
    logic       accept_start, capture, last_cg, last_fg, final_tile, drain_accept;

    function automatic logic [ADDR_W-1:0] layer_c(input logic [2:0] sel);
        case (sel)
            3'd0:          layer_c = ADDR_W'(64);
            3'd1, 3'd2:    layer_c = ADDR_W'(128);
            3'd3, 3'd4:    layer_c = ADDR_W'(256);
            3'd5, 3'd6:    layer_c = ADDR_W'(384);
            default:       layer_c = ADDR_W'(512);
        endcase
    endfunction

    function automatic logic [7:0] layer_nfg(input logic [2:0] sel);
        case (sel)
            3'd0, 3'd1: layer_nfg = 8'd2;
            3'd2, 3'd3: layer_nfg = 8'd4;
            3'd4, 3'd5: layer_nfg = 8'd6;
            default:    layer_nfg = 8'd8;
        endcase
    endfunction

    function automatic logic [7:0] layer_ncg(input logic [2:0] sel);
        case (sel)
            3'd0:       layer_ncg = 8'd4;
            3'd1, 3'd2: layer_ncg = 8'd8;
            3'd3, 3'd4: layer_ncg = 8'd16;
            3'd5, 3'd6: layer_ncg = 8'd24;
            default:    layer_ncg = 8'd32;
        endcase
    endfunction

    // Filter-major weight index: (fg*PAR_F + f) * C + cg*PAR_CH + c
    function automatic logic [PAR_F*PAR_CH*ADDR_W-1:0] tile_addr(
        input logic [ADDR_W-1:0] clen,
        input logic [7:0]        fgi,
        input logic [7:0]        cgi
    );
        logic [ADDR_W-1:0] frow;
        tile_addr = '0;
        for (int f = 0; f < PAR_F; f++) begin
            frow = (ADDR_W'(fgi) * ADDR_W'(PAR_F) + ADDR_W'(f)) * clen
                 + ADDR_W'(cgi) * ADDR_W'(PAR_CH);
            for (int c = 0; c < PAR_CH; c++)
                tile_addr[(f*PAR_CH+c)*ADDR_W +: ADDR_W] = frow + ADDR_W'(c);
        end
    endfunction

    function automatic logic [PAR_F*ADDR_W-1:0] bias_addr(input logic [7:0] fgi);
        bias_addr = '0;
        for (int f = 0; f < PAR_F; f++)
            bias_addr[f*ADDR_W +: ADDR_W] = ADDR_W'(fgi) * ADDR_W'(PAR_F) + ADDR_W'(f);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (capture && final_tile) state_nx = DRAIN;
            DRAIN:   if (drain_accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        accept_start = (state == IDLE) && start;
        capture      = (state == RUN) && (!w_valid || w_ready);
        drain_accept = (state == DRAIN) && w_valid && w_ready;
        last_cg      = (cg == layer_ncg(firesel_q) - 8'd1);
        last_fg      = (fg == layer_nfg(firesel_q) - 8'd1);
        final_tile   = last_cg && last_fg;
        cg_nx        = last_cg ? 8'd0 : cg + 8'd1;
        fg_nx        = last_cg ? fg + 8'd1 : fg;
    end

    // The address for the next tile is registered one beat ahead so the
    // combinational ROM read is captured on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            firesel_q <= '0;
            fg        <= '0;
            cg        <= '0;
            addr      <= '0;
            addrfilt  <= '0;
            w_valid   <= 1'b0;
            w_data    <= '0;
            w_bias    <= '0;
            w_last_ch <= 1'b0;
            w_last    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_start) begin
                firesel_q <= firesel;
                fg        <= '0;
                cg        <= '0;
                addr      <= tile_addr(layer_c(firesel), 8'd0, 8'd0);
                addrfilt  <= bias_addr(8'd0);
            end
            if (capture) begin
                w_data    <= rom_data;
                w_bias    <= rom_bias;
                w_valid   <= 1'b1;
                w_last_ch <= last_cg;
                w_last    <= final_tile;
                if (!final_tile) begin
                    fg       <= fg_nx;
                    cg       <= cg_nx;
                    addr     <= tile_addr(layer_c(firesel_q), fg_nx, cg_nx);
                    addrfilt <= bias_addr(fg_nx);
                end
            end
            if (drain_accept) begin
                w_valid <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_squeeze_weight_fetch.sv
// tb/tb_squeeze_weight_fetch.sv - randomized self-checking bench for squeeze_weight_fetch
module tb_squeeze_weight_fetch;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int PC = 16;
    localparam int PF = 8;
    localparam int NL = PF * PC;

    logic               clk = 1'b0;
    logic               reset, start, w_ready;
    logic [2:0]         firesel, firesel_q;
    logic [NL*AW-1:0]   addr;
    logic [PF*AW-1:0]   addrfilt;
    logic [NL*DW-1:0]   rom_data, w_data;
    logic [PF*DW-1:0]   rom_bias, w_bias;
    logic               w_valid, w_last_ch, w_last, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    squeeze_weight_fetch #(.ADDR_W(AW), .DATA_W(DW), .PAR_CH(PC), .PAR_F(PF)) dut (
        .clk(clk), .reset(reset), .start(start), .firesel(firesel), .firesel_q(firesel_q),
        .addr(addr), .addrfilt(addrfilt), .rom_data(rom_data), .rom_bias(rom_bias),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_bias(w_bias),
        .w_last_ch(w_last_ch), .w_last(w_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ROM model: each word holds the low bits of its own address
    always_comb begin
        rom_data = '0;
        rom_bias = '0;
        for (int l = 0; l < NL; l++) rom_data[l*DW +: DW] = addr[l*AW +: DW];
        for (int f = 0; f < PF; f++) rom_bias[f*DW +: DW] = addrfilt[f*AW +: DW];
    end

    int lay_s[8] = '{16, 16, 32, 32, 48, 48, 64, 64};
    int lay_c[8] = '{64, 128, 128, 256, 256, 384, 384, 512};

    function automatic int n_tiles(int sel);
        return (lay_s[sel] / 8) * (lay_c[sel] / 16);
    endfunction

    function automatic logic [NL*DW-1:0] exp_data(int sel, int t);
        int ncg, fg, cg;
        ncg = lay_c[sel] / 16;
        fg  = t / ncg;
        cg  = t % ncg;
        exp_data = '0;
        for (int f = 0; f < PF; f++)
            for (int c = 0; c < PC; c++)
                exp_data[(f*PC+c)*DW +: DW] = 16'((fg*8 + f) * lay_c[sel] + cg*16 + c);
    endfunction

    function automatic logic [PF*DW-1:0] exp_bias(int sel, int t);
        int fg;
        fg = t / (lay_c[sel] / 16);
        exp_bias = '0;
        for (int f = 0; f < PF; f++) exp_bias[f*DW +: DW] = 16'(fg*8 + f);
    endfunction

    function automatic logic exp_lch(int sel, int t);
        return (t % (lay_c[sel] / 16)) == (lay_c[sel] / 16) - 1;
    endfunction

    logic [NL*DW-1:0] obs_data[$];
    logic [PF*DW-1:0] obs_bias[$];
    logic             obs_lch[$];
    logic             obs_last[$];
    int ndone, busy_gap, unstable, lat, last_acc_cyc, done_cyc, timed_out;

    // mode 0: ready high, 2: 5-cycle stall on tile 2, 3: random ready, 4: stray start during RUN
    task automatic run_layer(input logic [2:0] sel, input int mode, input int stop_after, input int max_cyc);
        int hold;
        logic pend;
        logic [NL*DW-1:0] pd;
        logic [PF*DW-1:0] pb;
        logic [NL*AW-1:0] pa;
        obs_data.delete(); obs_bias.delete(); obs_lch.delete(); obs_last.delete();
        ndone = 0; busy_gap = 0; unstable = 0; lat = -1; last_acc_cyc = -1; done_cyc = -1;
        timed_out = 0; hold = 0; pend = 1'b0; pd = '0; pb = '0; pa = '0;
        @(negedge clk);
        firesel = sel;
        start   = 1'b1;
        w_ready = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mode == 4 && cyc == 5) begin
                start   = 1'b1;
                firesel = 3'd5;
            end
            case (mode)
                2: begin
                    w_ready = 1'b1;
                    if (w_valid && obs_data.size() == 2 && hold < 5) begin
                        w_ready = 1'b0;
                        hold++;
                    end
                end
                3:       w_ready = 1'($urandom_range(0, 1));
                default: w_ready = 1'b1;
            endcase
            if (pend && (w_data !== pd || w_bias !== pb || addr !== pa)) unstable++;
            pend = w_valid && !w_ready;
            pd = w_data; pb = w_bias; pa = addr;
            if (lat < 0 && w_valid) lat = cyc;
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc < 0 && busy !== 1'b1) busy_gap++;
            if (w_valid && w_ready) begin
                obs_data.push_back(w_data);
                obs_bias.push_back(w_bias);
                obs_lch.push_back(w_last_ch);
                obs_last.push_back(w_last);
                if (w_last) last_acc_cyc = cyc;
            end
            if (stop_after > 0 && obs_data.size() == stop_after) return;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) return;
        end
        timed_out = 1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; firesel = 3'd0; w_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({w_valid, w_last, w_last_ch, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {w_valid, w_last, w_last_ch, busy, done});
        end
        n_checks++;
        if (addr !== '0 || addrfilt !== '0 || firesel_q !== 3'd0 || w_data !== '0 || w_bias !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: addr0=%0d filt0=%0d fsq=%0d want all zero",
                     addr[AW-1:0], addrfilt[AW-1:0], firesel_q);
        end
        reset = 1'b0;
    endtask

    task automatic test_fire0;
        logic [NL*DW-1:0] t;
        run_layer(3'd0, 0, 0, 200);
        n_checks++;
        if (timed_out != 0 || obs_data.size() != 8) begin
            n_fail++;
            $display("FAIL fire0_count: got %0d tiles (timeout=%0d) want 8", obs_data.size(), timed_out);
        end
        n_checks++;
        if (lat != 2) begin n_fail++; $display("FAIL fire0_latency: got %0d want 2", lat); end
        if (obs_data.size() == 8) begin
            t = obs_data[0];
            n_checks++;
            if (t[0 +: DW] !== 16'd0 || t[15*DW +: DW] !== 16'd15 || t[(7*PC)*DW +: DW] !== 16'd448) begin
                n_fail++;
                $display("FAIL fire0_tile0: got %0d %0d %0d want 0 15 448",
                         t[0 +: DW], t[15*DW +: DW], t[(7*PC)*DW +: DW]);
            end
            n_checks++;
            if (obs_bias[0] !== exp_bias(0, 0) || obs_bias[0][7*DW +: DW] !== 16'd7) begin
                n_fail++;
                $display("FAIL fire0_bias0: got lane7=%0d want 7", obs_bias[0][7*DW +: DW]);
            end
            t = obs_data[3];
            n_checks++;
            if (t[0 +: DW] !== 16'd48 || obs_lch[3] !== 1'b1 || obs_last[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL fire0_tile3: got %0d lch=%b last=%b want 48 1 0", t[0 +: DW], obs_lch[3], obs_last[3]);
            end
            t = obs_data[4];
            n_checks++;
            if (t[0 +: DW] !== 16'd512 || obs_bias[4][0 +: DW] !== 16'd8 || obs_bias[4][7*DW +: DW] !== 16'd15) begin
                n_fail++;
                $display("FAIL fire0_tile4: got %0d bias %0d..%0d want 512 8..15",
                         t[0 +: DW], obs_bias[4][0 +: DW], obs_bias[4][7*DW +: DW]);
            end
            n_checks++;
            if (obs_last[7] !== 1'b1 || obs_last[6] !== 1'b0) begin
                n_fail++;
                $display("FAIL fire0_last: got t6=%b t7=%b want 0 1", obs_last[6], obs_last[7]);
            end
        end
        n_checks++;
        if (ndone != 1 || done_cyc - last_acc_cyc != 1) begin
            n_fail++;
            $display("FAIL fire0_done: got pulses=%0d gap=%0d want 1 1", ndone, done_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_fire7;
        int bad;
        run_layer(3'd7, 0, 0, 600);
        n_checks++;
        if (timed_out != 0 || obs_data.size() != 256) begin
            n_fail++;
            $display("FAIL fire7_count: got %0d tiles (timeout=%0d) want 256", obs_data.size(), timed_out);
        end
        bad = 0;
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_data(7, i) || obs_bias[i] !== exp_bias(7, i) ||
                obs_lch[i] !== exp_lch(7, i) || obs_last[i] !== (i == 255)) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL fire7_tile%0d: got lane0=%0d want %0d", i,
                                        obs_data[i][0 +: DW], exp_data(7, i)[0 +: DW]);
            end
        end
        if (obs_data.size() == 256) begin
            n_checks++;
            if (obs_data[255][(7*PC+15)*DW +: DW] !== 16'd32767 || obs_bias[255][7*DW +: DW] !== 16'd63) begin
                n_fail++;
                $display("FAIL fire7_final_lane: got %0d bias %0d want 32767 63",
                         obs_data[255][(7*PC+15)*DW +: DW], obs_bias[255][7*DW +: DW]);
            end
        end
        n_checks++;
        if (busy_gap != 0 || ndone != 1) begin
            n_fail++;
            $display("FAIL fire7_busy_done: got busy_gaps=%0d pulses=%0d want 0 1", busy_gap, ndone);
        end
    endtask

    task automatic test_backpressure;
        run_layer(3'd0, 2, 0, 200);
        n_checks++;
        if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        n_checks++;
        if (obs_data.size() != 8 || timed_out != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d tiles want 8", obs_data.size());
        end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_data(0, i) || obs_bias[i] !== exp_bias(0, i)) begin
                n_fail++;
                $display("FAIL bp_tile%0d: got lane0=%0d want %0d", i, obs_data[i][0 +: DW], exp_data(0, i)[0 +: DW]);
            end
        end
    endtask

    task automatic test_start_ignored;
        run_layer(3'd1, 4, 0, 200);
        n_checks++;
        if (firesel_q !== 3'd1) begin n_fail++; $display("FAIL ign_firesel_q: got %0d want 1", firesel_q); end
        n_checks++;
        if (obs_data.size() != n_tiles(1) || ndone != 1) begin
            n_fail++;
            $display("FAIL ign_count: got %0d tiles %0d done want %0d 1", obs_data.size(), ndone, n_tiles(1));
        end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_data(1, i) || obs_last[i] !== (i == n_tiles(1) - 1)) begin
                n_fail++;
                $display("FAIL ign_tile%0d: got lane0=%0d want %0d", i, obs_data[i][0 +: DW], exp_data(1, i)[0 +: DW]);
            end
        end
    endtask

    task automatic test_reset_midrun;
        run_layer(3'd3, 0, 3, 100);
        reset = 1'b1;
        @(negedge clk);
        w_ready = 1'b0;
        n_checks++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || addr !== '0 || firesel_q !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_state: got valid=%b busy=%b addr0=%0d fsq=%0d want 0 0 0 0",
                     w_valid, busy, addr[AW-1:0], firesel_q);
        end
        reset = 1'b0;
        @(negedge clk);
        run_layer(3'd3, 0, 0, 300);
        n_checks++;
        if (obs_data.size() != n_tiles(3) || obs_data[0][0 +: DW] !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_restart: got %0d tiles lane0=%0d want %0d 0",
                     obs_data.size(), obs_data.size() > 0 ? obs_data[0][0 +: DW] : 16'hffff, n_tiles(3));
        end
    endtask

    task automatic test_random_ready;
        run_layer(3'd2, 3, 0, 2000);
        n_checks++;
        if (obs_data.size() != 32 || timed_out != 0 || ndone != 1) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d tiles done=%0d want 32 1", obs_data.size(), ndone);
        end
        n_checks++;
        if (unstable != 0) begin n_fail++; $display("FAIL rnd_stable: got %0d changes want 0", unstable); end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_data(2, i) || obs_bias[i] !== exp_bias(2, i) ||
                obs_lch[i] !== exp_lch(2, i) || obs_last[i] !== (i == 31)) begin
                n_fail++;
                $display("FAIL rnd_tile%0d: got lane0=%0d want %0d", i, obs_data[i][0 +: DW], exp_data(2, i)[0 +: DW]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fire0();
        test_fire7();
        test_backpressure();
        test_start_ignored();
        test_reset_midrun();
        test_random_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
